// File: rtl/async_fifo_rd_ctrl.sv
// Async FIFO read-side control: write-pointer sync, read pointers, empty/almost_empty/underflow; FIFO_RD_COUNT_EN adds rd_count.
// Latency: write-pointer change seen on empty within SYNC_STAGES+1 edges; reads while empty are dropped and flagged as underflow.
module async_fifo_rd_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int AE_TH       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   wr_gray_ptr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   rd_gray_ptr,
  output logic              empty,
  output logic              almost_empty,
  output logic              underflow,
  output logic [ADDR_W:0]   rd_count
);

  localparam logic [ADDR_W:0] AE_LIM = (ADDR_W+1)'(AE_TH);

  logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
  logic [ADDR_W:0] wq_gray;
  logic [ADDR_W:0] wq_bin;
  logic [ADDR_W:0] rd_bin;
  logic [ADDR_W:0] rd_bin_next;
  logic [ADDR_W:0] rd_gray_next;
  logic [ADDR_W:0] occ_next;
  logic            rd_fire;

  assign wq_gray = sync_q[SYNC_STAGES-1];

  // Each binary bit is the parity of all Gray bits at or above it.
  always_comb begin
    wq_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      wq_bin[i] = ^(wq_gray >> i);
    end
  end

  assign rd_fire      = rd_en & ~empty;
  assign rd_bin_next  = rd_bin + {{ADDR_W{1'b0}}, rd_fire};
  assign rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1);
  assign occ_next     = wq_bin - rd_bin_next;
  assign rd_addr      = rd_bin[ADDR_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      rd_bin       <= '0;
      rd_gray_ptr  <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      underflow    <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], wr_gray_ptr};
      rd_bin       <= rd_bin_next;
      rd_gray_ptr  <= rd_gray_next;
      // Compared against the pre-edge synchronized pointer, so empty can only release late.
      empty        <= (rd_gray_next == wq_gray);
      almost_empty <= (occ_next <= AE_LIM);
      underflow    <= rd_en & empty;
    end
  end

`ifdef FIFO_RD_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
    end else begin
      rd_count <= occ_next;
    end
  end
`else
  assign rd_count = '0;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Bench for async_fifo_rd_ctrl: directed scenarios plus random traffic against an integer occupancy model.
module tb_async_fifo_rd_ctrl;

  localparam int AW  = 4;
  localparam int SS  = 2;
  localparam int AE  = 2;
  localparam int MOD = 1 << (AW + 1);
  localparam int DEP = 1 << AW;

  logic          clk;
  logic          rst;
  logic          rd_en;
  logic [AW:0]   wr_gray_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   rd_gray_ptr;
  logic          empty;
  logic          almost_empty;
  logic          underflow;
  logic [AW:0]   rd_count;

  async_fifo_rd_ctrl #(.ADDR_W(AW), .SYNC_STAGES(SS), .AE_TH(AE)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_gray_ptr(wr_gray_ptr),
    .rd_addr(rd_addr), .rd_gray_ptr(rd_gray_ptr), .empty(empty),
    .almost_empty(almost_empty), .underflow(underflow), .rd_count(rd_count)
  );

  typedef struct {
    int addr;
    int gray;
    int emp;
    int ae;
    int uf;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   clk_run = 0;

  // Reference state: read count, write count, and the write count as seen through the sync delay.
  int   rc = 0;
  int   wp = 0;
  int   syn[SS];
  bit   m_empty = 1;

  initial begin
    clk = 0;
    wait (clk_run);
    forever #5 clk = ~clk;
  end

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic void chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    rc = 0;
    m_empty = 1;
    for (int k = 0; k < SS; k++) syn[k] = 0;
    exp_q.delete();
  endtask

  // Called at a negedge: drives inputs for the next posedge, predicts its outcome, returns at the following negedge.
  task automatic cycle(input bit en, input int wnext);
    exp_t e;
    int   wq;
    int   occ;
    bit   fire;
    rd_en       = en;
    wp          = wnext % MOD;
    wr_gray_ptr = gray(wp);
    fire = en && !m_empty;
    e.uf = int'(en && m_empty);
    rc   = (rc + (fire ? 1 : 0)) % MOD;
    wq   = syn[SS-1];
    for (int k = SS - 1; k > 0; k--) syn[k] = syn[k-1];
    syn[0] = wp;
    occ     = (wq - rc + MOD) % MOD;
    m_empty = (occ == 0);
    e.addr  = rc % DEP;
    e.gray  = int'(gray(rc));
    e.emp   = int'(m_empty);
    e.ae    = int'(occ <= AE);
`ifdef FIFO_RD_COUNT_EN
    e.cnt   = occ;
`else
    e.cnt   = 0;
`endif
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_rd_addr", int'(rd_addr), e.addr);
        chk("sb_rd_gray_ptr", int'(rd_gray_ptr), e.gray);
        chk("sb_empty", int'(empty), e.emp);
        chk("sb_almost_empty", int'(almost_empty), e.ae);
        chk("sb_underflow", int'(underflow), e.uf);
        chk("sb_rd_count", int'(rd_count), e.cnt);
      end
    end
  end

  initial begin : driver
    int g3[5] = '{1, 3, 2, 6, 7};
    int guard;
    int rd_p;
    int wr_p;
    int nxt;
    rst = 0;
    rd_en = 0;
    wr_gray_ptr = '0;
    model_reset();

    // 1: reset with no clock
    #2 rst = 1;
    #1;
    chk("rst_empty", int'(empty), 1);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_rd_gray_ptr", int'(rd_gray_ptr), 0);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_rd_count", int'(rd_count), 0);
    clk_run = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    cycle(0, 0);
    cycle(0, 0);

    // 2: one word, empty released on the 3rd edge
    cycle(0, 1);
    chk("t2_empty_edge1", int'(empty), 1);
    cycle(0, 1);
    chk("t2_empty_edge2", int'(empty), 1);
    cycle(0, 1);
    chk("t2_empty_edge3", int'(empty), 0);
    chk("t2_almost_empty", int'(almost_empty), 1);
`ifdef FIFO_RD_COUNT_EN
    chk("t2_rd_count", int'(rd_count), 1);
`endif

    // 3: five words, five back-to-back reads
    cycle(0, 5);
    cycle(0, 5);
    cycle(0, 5);
    chk("t3_ae_before", int'(almost_empty), 0);
    for (int i = 0; i < 5; i++) begin
      chk("t3_rd_addr", int'(rd_addr), i);
      cycle(1, 5);
      chk("t3_rd_gray_ptr", int'(rd_gray_ptr), g3[i]);
      chk("t3_almost_empty", int'(almost_empty), (i >= 2) ? 1 : 0);
      chk("t3_empty", int'(empty), (i == 4) ? 1 : 0);
    end

    // 4: read while empty
    cycle(1, 5);
    chk("t4_underflow_hi", int'(underflow), 1);
    chk("t4_rd_addr", int'(rd_addr), 5);
    chk("t4_rd_gray_ptr", int'(rd_gray_ptr), 7);
    cycle(0, 5);
    chk("t4_underflow_lo", int'(underflow), 0);
    chk("t4_rd_gray_hold", int'(rd_gray_ptr), 7);

    // 5: walk both pointers to 31, then wrap through 0
    guard = 0;
    while (rc != MOD - 1 && guard < 200) begin
      cycle(1, (wp != MOD - 1) ? wp + 1 : wp);
      guard++;
    end
    chk("t5_walk_bound", rc, MOD - 1);
    cycle(0, MOD - 1);
    cycle(0, MOD - 1);
    cycle(0, MOD - 1);
    chk("t5_rd_addr_15", int'(rd_addr), 15);
    chk("t5_rd_gray_10000", int'(rd_gray_ptr), 16);
    chk("t5_empty_before", int'(empty), 1);
    cycle(0, 0);
    cycle(0, 0);
    cycle(0, 0);
    chk("t5_empty_word", int'(empty), 0);
    cycle(1, 0);
    chk("t5_rd_addr_0", int'(rd_addr), 0);
    chk("t5_rd_gray_0", int'(rd_gray_ptr), 0);
    chk("t5_empty_after", int'(empty), 1);
    chk("t5_no_underflow", int'(underflow), 0);
    cycle(0, 0);
    chk("t5_no_underflow2", int'(underflow), 0);

    // 6: reset in the middle of a read burst
    cycle(0, 8);
    cycle(0, 8);
    cycle(0, 8);
    cycle(1, 8);
    cycle(1, 8);
    cycle(1, 8);
    chk("t6_rd_addr_pre", int'(rd_addr), 3);
    #2 rst = 1;
    #1;
    chk("t6_rst_empty", int'(empty), 1);
    chk("t6_rst_rd_addr", int'(rd_addr), 0);
    chk("t6_rst_rd_gray", int'(rd_gray_ptr), 0);
    rd_en = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    cycle(0, 8);
    cycle(0, 8);
    chk("t6_empty_edge2", int'(empty), 1);
    cycle(0, 8);
    chk("t6_empty_edge3", int'(empty), 0);

    // Random traffic; the writer never exceeds a full memory.
    for (int seg = 0; seg < 6; seg++) begin
      rd_p = $urandom_range(10, 95);
      wr_p = $urandom_range(10, 95);
      for (int n = 0; n < 500; n++) begin
        nxt = wp;
        if (((wp - rc + MOD) % MOD) < DEP && $urandom_range(0, 99) < wr_p)
          nxt = wp + 1;
        cycle($urandom_range(0, 99) < rd_p, nxt);
      end
    end
    cycle(0, wp);
    cycle(0, wp);

    chk("sb_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/async_fifo_rd_ctrl.md
Name: async_fifo_rd_ctrl

Overview:
Read-domain control half of the asynchronous FIFO. It is the reader counterpart to the write-side pointer logic. It synchronizes the write-domain Gray pointer into the read clock domain and keeps the binary and Gray read pointers. It generates empty, almost_empty and underflow status, and drives the read address to the shared dual-port memory.

Parameters:
ADDR_W, 4, memory address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, number of flops in the write-pointer synchronizer; legal values 2..3.
AE_TH, 2, almost-empty threshold in words; legal values 1..2**ADDR_W-1.

Ports:
clk  input  1  read-domain clock; all state is on its posedge.
rst  input  1  asynchronous, active-high reset; asserts immediately, release is synchronous to clk.
rd_en  input  1  read request from the consumer.
wr_gray_ptr  input  ADDR_W+1  write pointer in Gray code, from the write clock domain (asynchronous).
rd_addr  output  ADDR_W  read address to the memory; equals rd_bin[ADDR_W-1:0].
rd_gray_ptr  output  ADDR_W+1  registered Gray read pointer, sent to the write domain.
empty  output  1  registered; high means no readable words.
almost_empty  output  1  registered; high when occupancy <= AE_TH.
underflow  output  1  one-cycle pulse on a read attempt while empty.
rd_count  output  ADDR_W+1  occupancy estimate; see Optional Feature.

Behaviour:
- Reset values: rd_bin=0, rd_gray_ptr=0, all synchronizer flops=0, empty=1, almost_empty=1, underflow=0, rd_count=0.
- Synchronizer: wr_gray_ptr passes through SYNC_STAGES flops to give wq_gray. wq_bin is the Gray-to-binary conversion of wq_gray.
- Read acceptance: rd_fire = rd_en & ~empty.
  - rd_bin_next = rd_bin + rd_fire, wrapping modulo 2**(ADDR_W+1).
  - rd_gray_next = rd_bin_next ^ (rd_bin_next >> 1).
  - rd_bin and rd_gray_ptr both register their next values.
- rd_addr presents the address of the word being read in the current cycle. The memory read is combinational or one-cycle, owned by the memory.
- Empty: empty <= (rd_gray_next == wq_gray). A read of the last word asserts empty on the same edge that advances the pointer.
- Occupancy: occ_next = (wq_bin - rd_bin_next) mod 2**(ADDR_W+1). almost_empty <= (occ_next <= AE_TH), so almost_empty is also high whenever empty is high.
- Underflow: underflow <= rd_en & empty. When this occurs the pointers do not move and the memory is not addressed as a valid read.
- Latency: a write-pointer change that is stable at the write side deasserts empty no later than SYNC_STAGES+1 posedges of clk.
- Wrap-around: pointer MSB toggles each pass through the memory. Full/empty disambiguation relies on the MSB. Gray code changes exactly one bit per increment, including the 2**(ADDR_W+1)-1 -> 0 step.
- Simultaneous events:
  - rd_en on the same cycle that wq_gray advances: the read uses the registered empty from the previous edge.
  - The new empty is computed from the updated rd_gray_next and wq_gray.
- Reset mid-operation: all registers, including the synchronizer, clear asynchronously. empty goes high without waiting for a clock edge. A read in flight is discarded.
- Pessimism: empty and almost_empty can only be late-deasserted, never early-deasserted. Reads are never issued on stale data.

Optional Feature:
Macro: FIFO_RD_COUNT_EN.
- Defined: rd_count <= occ_next each cycle; reset 0; range 0..2**ADDR_W.
- Undefined: rd_count is tied to 0, and no subtractor is used beyond the one the almost_empty logic needs.

Test Plan:
1. Assert rst with no clock running -> immediately empty=1, almost_empty=1, rd_addr=0, rd_gray_ptr=0, underflow=0, rd_count=0.
2. Release reset, then drive wr_gray_ptr 0 -> 5'b00001 (one word) -> empty=0 on the 3rd posedge (SYNC_STAGES=2); almost_empty stays 1; rd_count=1 if FIFO_RD_COUNT_EN.
3. Drive wr_gray_ptr = gray(5) = 5'b00111, then hold rd_en=1 for 5 cycles:
   - rd_addr steps 0,1,2,3,4;
   - rd_gray_ptr steps 1,3,2,6,7;
   - almost_empty rises after the 3rd read;
   - empty rises on the 5th read edge.
4. With empty=1, pulse rd_en for 1 cycle -> underflow=1 for exactly one cycle; rd_addr and rd_gray_ptr unchanged.
5. Advance both pointers to 31, write 1 more word (wr_gray = gray(0) = 0), then read it:
   - rd_addr goes 15 -> 0;
   - rd_gray_ptr goes 5'b10000 -> 5'b00000;
   - empty=1 afterwards, with no spurious underflow.
6. Drive wr_gray_ptr = gray(8) = 5'b01100, complete 3 reads, then assert rst mid-read -> empty=1 and rd_addr=0 asynchronously; after release, empty deasserts again after 3 edges.
